alu_issue_ctrl: RTL and testbench

Command-issue and result-collection stage that sits directly upstream of the 4-bit sequential ALU, which registers its inputs and its output on the falling clock edge. It buffers incoming operation commands, drives the ALU operand and opcode inputs one command per cycle, and tracks the ALU's fixed pipeline latency. ALU outputs are captured into a result FIFO with their opcode tag. A credit scheme prevents result overflow under downstream backpressure.

---
 rtl/alu_issue_if.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: command, ALU-drive and result bundle of the ALU issue stage.
// slave = issue controller side, master = producer/ALU/consumer side.
interface alu_issue_if #(
    parameter int CMD_DEPTH = 4
);
    localparam int CCW = $clog2(CMD_DEPTH) + 1;

    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_a;
    logic [3:0]     in_b;
    logic [1:0]     in_op;

    logic [3:0]     alu_a;
    logic [3:0]     alu_b;
    logic [1:0]     alu_op;
    logic [7:0]     alu_out;

    logic           res_valid;
    logic           res_ready;
    logic [7:0]     res_data;
    logic [1:0]     res_op;

    logic [CCW-1:0] cmd_count;

    modport slave (
        input  in_valid, in_a, in_b, in_op,
        input  alu_out, res_ready,
        output in_ready, alu_a, alu_b, alu_op,
        output res_valid, res_data, res_op, cmd_count
    );

    modport master (
        output in_valid, in_a, in_b, in_op,
        output alu_out, res_ready,
        input  in_ready, alu_a, alu_b, alu_op,
        input  res_valid, res_data, res_op, cmd_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers commands, issues one per cycle to a sequential ALU,
// tracks its fixed latency and collects tagged results under credit control.
// Ports: clk; rst (async, active-high); bus (slave modport of alu_issue_if):
//   in_* command handshake, alu_a/b/op drive, alu_out return,
//   res_* result handshake, cmd_count command FIFO occupancy.
module alu_issue_ctrl #(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int LAT       = 2
) (
    input  logic       clk,
    input  logic       rst,
    alu_issue_if.slave bus
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int CCW = CAW + 1;
    localparam int RCW = RAW + 1;

    localparam logic [CCW-1:0] CMD_FULL = CCW'(CMD_DEPTH);
    localparam logic [CAW-1:0] CA_ONE   = CAW'(1);
    localparam logic [RAW-1:0] RA_ONE   = RAW'(1);
    localparam logic [CCW-1:0] CC_ONE   = CCW'(1);
    localparam logic [RCW-1:0] RC_ONE   = RCW'(1);

    logic [9:0]     cmd_mem_q [CMD_DEPTH];
    logic [CAW-1:0] cmd_wp_q, cmd_wp_d;
    logic [CAW-1:0] cmd_rp_q, cmd_rp_d;
    logic [CCW-1:0] cmd_cnt_q, cmd_cnt_d;

    logic [9:0]     res_mem_q [RES_DEPTH];
    logic [RAW-1:0] res_wp_q, res_wp_d;
    logic [RAW-1:0] res_rp_q, res_rp_d;
    logic [RCW-1:0] res_cnt_q, res_cnt_d;

    logic [LAT-1:0] vld_q, vld_d;
    logic [1:0]     tag_q [LAT];

    logic [3:0]     alu_a_q, alu_b_q;
    logic [1:0]     alu_op_q;

    logic           push, issue, capture, pop;
    logic           credit_ok;
    logic [9:0]     head_cmd;
    logic [9:0]     head_res;

    assign head_cmd = cmd_mem_q[cmd_rp_q];
    assign head_res = res_mem_q[res_rp_q];

    assign bus.in_ready  = (cmd_cnt_q < CMD_FULL);
    assign bus.cmd_count = cmd_cnt_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.res_valid = (res_cnt_q != '0);
    assign bus.res_data  = head_res[9:2];
    assign bus.res_op    = head_res[1:0];

    // Every in-flight op owns a result slot, so the result FIFO can never
    // overflow. Counts are pre-edge: a pop frees its credit one cycle late.
    assign credit_ok = (int'(res_cnt_q) + $countones(vld_q)) < RES_DEPTH;

    assign push    = bus.in_valid && bus.in_ready;
    assign issue   = (cmd_cnt_q != '0) && credit_ok;
    assign capture = vld_q[LAT-1];
    assign pop     = bus.res_valid && bus.res_ready;

    always_comb begin
        cmd_wp_d = push  ? cmd_wp_q + CA_ONE : cmd_wp_q;
        cmd_rp_d = issue ? cmd_rp_q + CA_ONE : cmd_rp_q;
        res_wp_d = capture ? res_wp_q + RA_ONE : res_wp_q;
        res_rp_d = pop     ? res_rp_q + RA_ONE : res_rp_q;

        cmd_cnt_d = cmd_cnt_q;
        unique case ({push, issue})
            2'b10:   cmd_cnt_d = cmd_cnt_q + CC_ONE;
            2'b01:   cmd_cnt_d = cmd_cnt_q - CC_ONE;
            default: cmd_cnt_d = cmd_cnt_q;
        endcase

        res_cnt_d = res_cnt_q;
        unique case ({capture, pop})
            2'b10:   res_cnt_d = res_cnt_q + RC_ONE;
            2'b01:   res_cnt_d = res_cnt_q - RC_ONE;
            default: res_cnt_d = res_cnt_q;
        endcase

        vld_d    = vld_q << 1;
        vld_d[0] = issue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CMD_DEPTH; i++) cmd_mem_q[i] <= '0;
            for (int i = 0; i < RES_DEPTH; i++) res_mem_q[i] <= '0;
            for (int i = 0; i < LAT; i++)       tag_q[i]     <= 2'b00;
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            cmd_cnt_q <= '0;
            res_wp_q  <= '0;
            res_rp_q  <= '0;
            res_cnt_q <= '0;
            vld_q     <= '0;
            alu_a_q   <= 4'd0;
            alu_b_q   <= 4'd0;
            alu_op_q  <= 2'b00;
        end else begin
            if (push) begin
                cmd_mem_q[cmd_wp_q] <= {bus.in_a, bus.in_b, bus.in_op};
            end
            if (capture) begin
                res_mem_q[res_wp_q] <= {bus.alu_out, tag_q[LAT-1]};
            end
            if (issue) begin
                alu_a_q  <= head_cmd[9:6];
                alu_b_q  <= head_cmd[5:2];
                alu_op_q <= head_cmd[1:0];
            end
            tag_q[0] <= issue ? head_cmd[1:0] : 2'b00;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
            cmd_wp_q  <= cmd_wp_d;
            cmd_rp_q  <= cmd_rp_d;
            cmd_cnt_q <= cmd_cnt_d;
            res_wp_q  <= res_wp_d;
            res_rp_q  <= res_rp_d;
            res_cnt_q <= res_cnt_d;
            vld_q     <= vld_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vector table, multi-cycle corner sequences and
// a random run, against a falling-edge ALU model and in-order scoreboard.
module tb_alu_issue_ctrl;
    localparam int CMD_DEPTH = 4;
    localparam int RES_DEPTH = 4;
    localparam int LAT       = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if #(.CMD_DEPTH(CMD_DEPTH)) bus ();

    alu_issue_ctrl #(
        .CMD_DEPTH(CMD_DEPTH),
        .RES_DEPTH(RES_DEPTH),
        .LAT      (LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [7:0] res;
    } vec_t;

    vec_t       vecs [10];
    int         total = 0;
    int         bad   = 0;
    int         acc_n = 0;
    int         res_n = 0;
    logic [9:0] expq [$];
    logic [9:0] mon_exp;

    function automatic logic [7:0] ref_alu(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic [1:0] op);
        logic [7:0] r;
        case (op)
            2'b00:   r = 8'(a) + 8'(b);
            2'b01:   r = 8'(a) * 8'(b);
            2'b10:   r = {4'h0, a | b};
            default: r = {4'h0, a & b};
        endcase
        return r;
    endfunction

    // Sequential ALU: inputs and output registered on the falling edge.
    logic [3:0] ra  = 4'd0;
    logic [3:0] rb  = 4'd0;
    logic [1:0] rop = 2'b00;
    always @(negedge clk) begin
        ra          <= bus.alu_a;
        rb          <= bus.alu_b;
        rop         <= bus.alu_op;
        bus.alu_out <= ref_alu(ra, rb, rop);
    end

    // Scoreboard: record accepted commands, check popped results in order.
    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) begin
            expq.push_back({ref_alu(bus.in_a, bus.in_b, bus.in_op), bus.in_op});
            acc_n++;
        end
        if (!rst && bus.res_valid && bus.res_ready) begin
            res_n++;
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL res_extra: got data=%0d op=%0d want none",
                         bus.res_data, bus.res_op);
            end else begin
                mon_exp = expq.pop_front();
                if ({bus.res_data, bus.res_op} !== mon_exp) begin
                    bad++;
                    $display("FAIL res_stream: got data=%0d op=%0d want data=%0d op=%0d",
                             bus.res_data, bus.res_op, mon_exp[9:2], mon_exp[1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_in_ready"},  32'(bus.in_ready),  1);
        chk({p, "_alu_a"},     32'(bus.alu_a),     0);
        chk({p, "_alu_b"},     32'(bus.alu_b),     0);
        chk({p, "_alu_op"},    32'(bus.alu_op),    0);
        chk({p, "_res_valid"}, 32'(bus.res_valid), 0);
        chk({p, "_res_data"},  32'(bus.res_data),  0);
        chk({p, "_res_op"},    32'(bus.res_op),    0);
        chk({p, "_cmd_count"}, 32'(bus.cmd_count), 0);
    endtask

    task automatic drive(input logic v, input int a, input int b, input int op);
        bus.in_valid = v;
        bus.in_a     = 4'(a);
        bus.in_b     = 4'(b);
        bus.in_op    = 2'(op);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int k;
        int base;
        drive(1'b0, 0, 0, 0);
        bus.res_ready = 1'b0;

        vecs[0] = '{4'd3,  4'd5,  2'b00, 8'd8};
        vecs[1] = '{4'd15, 4'd15, 2'b01, 8'd225};
        vecs[2] = '{4'd12, 4'd10, 2'b10, 8'd14};
        vecs[3] = '{4'd12, 4'd10, 2'b11, 8'd8};
        vecs[4] = '{4'd15, 4'd15, 2'b00, 8'd30};
        vecs[5] = '{4'd0,  4'd9,  2'b01, 8'd0};
        vecs[6] = '{4'd0,  4'd0,  2'b10, 8'd0};
        vecs[7] = '{4'd15, 4'd15, 2'b11, 8'd15};
        vecs[8] = '{4'd7,  4'd9,  2'b01, 8'd63};
        vecs[9] = '{4'd9,  4'd6,  2'b10, 8'd15};

        #2 rst = 1'b1;
        #1;
        chk_reset("rst0");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single-command latency for each table vector.
        for (int v = 0; v < 10; v++) begin
            drive(1'b1, vecs[v].a, vecs[v].b, vecs[v].op);
            tick();
            bus.in_valid = 1'b0;
            chk("t0_cmd_count", 32'(bus.cmd_count), 1);
            chk("t0_res_valid", 32'(bus.res_valid), 0);
            tick();
            chk("t1_alu_a",     32'(bus.alu_a),     32'(vecs[v].a));
            chk("t1_alu_b",     32'(bus.alu_b),     32'(vecs[v].b));
            chk("t1_alu_op",    32'(bus.alu_op),    32'(vecs[v].op));
            chk("t1_cmd_count", 32'(bus.cmd_count), 0);
            chk("t1_res_valid", 32'(bus.res_valid), 0);
            tick();
            chk("t2_res_valid", 32'(bus.res_valid), 0);
            tick();
            chk("t3_res_valid", 32'(bus.res_valid), 1);
            chk("t3_res_data",  32'(bus.res_data),  32'(vecs[v].res));
            chk("t3_res_op",    32'(bus.res_op),    32'(vecs[v].op));
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
            chk("t4_res_valid", 32'(bus.res_valid), 0);
        end

        // Back-to-back mul/or/and with res_ready held high.
        bus.res_ready = 1'b1;
        for (int v = 1; v < 4; v++) begin
            drive(1'b1, vecs[v].a, vecs[v].b, vecs[v].op);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int v = 1; v < 4; v++) begin
            tick();
            chk("b2b_valid", 32'(bus.res_valid), 1);
            chk("b2b_data",  32'(bus.res_data),  32'(vecs[v].res));
            chk("b2b_op",    32'(bus.res_op),    32'(vecs[v].op));
        end
        tick();
        chk("b2b_idle", 32'(bus.res_valid), 0);

        // Backpressure: offer 10 commands with res_ready low.
        bus.res_ready = 1'b0;
        base = res_n;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            drive(k < 10, k, 15 - k, k);
            if (k < 10 && bus.in_ready) k++;
            tick();
        end
        chk("bp_accepted",  32'(k),              8);
        chk("bp_cmd_count", 32'(bus.cmd_count),  4);
        chk("bp_in_ready",  32'(bus.in_ready),   0);
        chk("bp_res_valid", 32'(bus.res_valid),  1);
        chk("bp_alu_a",     32'(bus.alu_a),      3);
        chk("bp_alu_b",     32'(bus.alu_b),      12);
        chk("bp_alu_op",    32'(bus.alu_op),     3);
        tick();
        chk("full_hold_cnt", 32'(bus.cmd_count), 4);
        chk("full_hold_rdy", 32'(bus.in_ready),  0);
        bus.res_ready = 1'b1;
        tick();
        chk("credit_lag_cnt", 32'(bus.cmd_count), 4);
        chk("credit_lag_rdy", 32'(bus.in_ready),  0);
        tick();
        chk("full_pop_cnt", 32'(bus.cmd_count), 3);
        chk("full_pop_rdy", 32'(bus.in_ready),  1);
        drive(1'b1, k, 15 - k, k);
        k++;
        tick();
        chk("push_pop_cnt", 32'(bus.cmd_count), 3);
        for (int c = 0; c < 40 && k < 10; c++) begin
            drive(1'b1, k, 15 - k, k);
            if (bus.in_ready) k++;
            tick();
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 60 && expq.size() != 0; c++) tick();
        chk("bp_queue_left", 32'(expq.size()),  0);
        chk("bp_drained",    32'(res_n - base), 10);
        chk("bp_idle",       32'(bus.res_valid), 0);

        // Mid-operation reset: 2 in flight, 3 queued.
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i + 2, i + 5, i);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i + 8, 3, i);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_cnt0", 32'(bus.cmd_count), 3);
        bus.res_ready = 1'b1;
        tick();
        drive(1'b1, 11, 4, 1);
        tick();
        bus.res_ready = 1'b0;
        drive(1'b1, 12, 4, 2);
        tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_cnt1", 32'(bus.cmd_count), 3);
        chk("pre_rst_alu_a", 32'(bus.alu_a),    9);
        #2 rst = 1'b1;
        expq.delete();
        #1;
        chk_reset("rst1");
        tick();
        tick();
        rst = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_valid", 32'(bus.res_valid), 0);
        end

        // Random traffic: 500 commands, random in_valid/res_ready.
        base = acc_n;
        for (int c = 0; c < 5000 && (acc_n - base) < 500; c++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            bus.res_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 100 && expq.size() != 0; c++) tick();
        chk("rnd_accepted",   32'(acc_n - base),  500);
        chk("rnd_queue_left", 32'(expq.size()),   0);
        chk("rnd_idle",       32'(bus.res_valid), 0);
        chk("rnd_cmd_count",  32'(bus.cmd_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
